sync_fifo_resp: RTL and testbench

//  Synthesizable single-clock FIFO responder. It is the storage end of the
//  wr_en/rd_en FIFO handshake that the fifo_0-style write/read stimulus

---
 rtl/sync_fifo_resp.sv | 172 +++++++++++++++++
 tb/tb_sync_fifo_resp.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_resp.sv
// sync_fifo_resp: single-clock FIFO responder with registered flags and a
// configurable read pipeline (1 or 2 clocks of read latency).
//
// Build option: define FIFO_WATER_LEVEL_EN to add wr_water_level and
// rd_water_level outputs, both mirroring the registered occupancy count.
//
// Ports
//   clk            clock, all logic on the rising edge
//   tb_rst         asynchronous active-high reset
//   wr_data        write data, stored when a write is accepted
//   wr_en          write request (dropped while wr_full)
//   wr_full        count == 2**DEPTH_WIDTH
//   almost_full    count >= ALMOST_FULL_NUM
//   rd_en          read request (dropped while rd_empty)
//   rd_data        read data, holds between read returns
//   rd_empty       count == 0
//   almost_empty   count <= ALMOST_EMPTY_NUM
//   wr_water_level occupancy count (FIFO_WATER_LEVEL_EN only)
//   rd_water_level occupancy count (FIFO_WATER_LEVEL_EN only)

module sync_fifo_resp #(
  parameter int unsigned DEPTH_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH       = 10,
  parameter int unsigned OUTPUT_REG       = 1,
  parameter int unsigned ALMOST_FULL_NUM  = 1020,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty
`ifdef FIFO_WATER_LEVEL_EN
  ,
  output logic [DEPTH_WIDTH:0]  wr_water_level,
  output logic [DEPTH_WIDTH:0]  rd_water_level
`endif
);

  localparam int unsigned Depth = 2 ** DEPTH_WIDTH;

  localparam logic [DEPTH_WIDTH:0] CntOne    = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] AfThresh  = ALMOST_FULL_NUM[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] AeThresh  = ALMOST_EMPTY_NUM[DEPTH_WIDTH:0];

  logic [DEPTH_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0] count_q, count_d;

  logic wr_full_q, wr_full_d;
  logic rd_empty_q, rd_empty_d;
  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;

  logic wr_acc;
  logic rd_acc;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [DATA_WIDTH-1:0] ram_rd_q, ram_rd_d;

  // Accept decisions use the registered (pre-edge) flags, so a full FIFO
  // still accepts a read and an empty FIFO never falls through.
  assign wr_acc = wr_en & ~wr_full_q;
  assign rd_acc = rd_en & ~rd_empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + CntOne;
    if (rd_acc) rd_ptr_d = rd_ptr_q + CntOne;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // Full/empty from the wrap-bit pointer pair; thresholds from the count.
    wr_full_d      = (wr_ptr_d[DEPTH_WIDTH-1:0] == rd_ptr_d[DEPTH_WIDTH-1:0]) &&
                     (wr_ptr_d[DEPTH_WIDTH] != rd_ptr_d[DEPTH_WIDTH]);
    rd_empty_d     = (wr_ptr_d == rd_ptr_d);
    almost_full_d  = (count_d >= AfThresh);
    almost_empty_d = (count_d <= AeThresh);
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Storage array, intentionally not reset. A write never targets the entry
  // being read: reads only hit occupied entries and writes are blocked at full.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  // RAM read register: loads only on an accepted read, otherwise holds.
  always_comb begin
    ram_rd_d = ram_rd_q;
    if (rd_acc) ram_rd_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      ram_rd_q <= '0;
    end else begin
      ram_rd_q <= ram_rd_d;
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic                  ram_vld_q;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    // Second stage only captures when the RAM register holds fresh read data,
    // so rd_data holds its value between reads.
    always_comb begin
      rd_data_d = rd_data_q;
      if (ram_vld_q) rd_data_d = ram_rd_q;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
        ram_vld_q <= 1'b0;
        rd_data_q <= '0;
      end else begin
        ram_vld_q <= rd_acc;
        rd_data_q <= rd_data_d;
      end
    end

    assign rd_data = rd_data_q;
  end else begin : g_no_out_reg
    assign rd_data = ram_rd_q;
  end

  assign wr_full      = wr_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

`ifdef FIFO_WATER_LEVEL_EN
  assign wr_water_level = count_q;
  assign rd_water_level = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_resp.sv
module tb_sync_fifo_resp;

  localparam int DW    = 10;
  localparam int AW    = 10;
  localparam int Depth = 1 << AW;
  localparam int AF    = 1020;
  localparam int AE    = 4;
  localparam int OREG  = 1;
  localparam int LAT   = OREG + 1;

  logic          clk;
  logic          tb_rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          almost_empty;
`ifdef FIFO_WATER_LEVEL_EN
  logic [AW:0]   wr_water_level;
  logic [AW:0]   rd_water_level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_resp #(
    .DEPTH_WIDTH     (AW),
    .DATA_WIDTH      (DW),
    .OUTPUT_REG      (OREG),
    .ALMOST_FULL_NUM (AF),
    .ALMOST_EMPTY_NUM(AE)
  ) dut (
    .clk           (clk),
    .tb_rst        (tb_rst),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .wr_full       (wr_full),
    .almost_full   (almost_full),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_empty      (rd_empty),
    .almost_empty  (almost_empty)
`ifdef FIFO_WATER_LEVEL_EN
    ,
    .wr_water_level(wr_water_level),
    .rd_water_level(rd_water_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: model contents, plus read returns queued with the edge
  // number at which they must show up on rd_data.
  typedef struct {
    int            due;
    logic [DW-1:0] dat;
  } pend_t;

  logic [DW-1:0] mq[$];
  pend_t         pq[$];
  logic [DW-1:0] m_rd = '0;
  int            edge_n = 0;

  always begin
    logic wa, ra;
    int   cnt;
    @(posedge clk);
    if (tb_rst) begin
      mq.delete();
      pq.delete();
      m_rd = '0;
    end else begin
      wa = wr_en && (mq.size() < Depth);
      ra = rd_en && (mq.size() != 0);
      if (ra) begin
        pq.push_back(pend_t'{due: edge_n + LAT - 1, dat: mq[0]});
        void'(mq.pop_front());
      end
      if (wa) mq.push_back(wr_data);
      while (pq.size() != 0 && pq[0].due == edge_n) begin
        m_rd = pq[0].dat;
        void'(pq.pop_front());
      end
    end
    edge_n++;
    #1;
    cnt = mq.size();
    n_tests += 5;
    if (rd_data !== m_rd) begin
      n_fail++;
      $display("FAIL sb_rd_data @%0t: got %0h expected %0h", $time, rd_data, m_rd);
    end
    if (rd_empty !== (cnt == 0)) begin
      n_fail++;
      $display("FAIL sb_rd_empty @%0t: got %b expected %b", $time, rd_empty, cnt == 0);
    end
    if (wr_full !== (cnt == Depth)) begin
      n_fail++;
      $display("FAIL sb_wr_full @%0t: got %b expected %b", $time, wr_full, cnt == Depth);
    end
    if (almost_full !== (cnt >= AF)) begin
      n_fail++;
      $display("FAIL sb_almost_full @%0t: got %b expected %b", $time, almost_full, cnt >= AF);
    end
    if (almost_empty !== (cnt <= AE)) begin
      n_fail++;
      $display("FAIL sb_almost_empty @%0t: got %b expected %b", $time, almost_empty,
               cnt <= AE);
    end
`ifdef FIFO_WATER_LEVEL_EN
    n_tests += 2;
    if (wr_water_level !== (AW+1)'(cnt)) begin
      n_fail++;
      $display("FAIL sb_wr_level @%0t: got %0d expected %0d", $time, wr_water_level, cnt);
    end
    if (rd_water_level !== (AW+1)'(cnt)) begin
      n_fail++;
      $display("FAIL sb_rd_level @%0t: got %0d expected %0d", $time, rd_water_level, cnt);
    end
`endif
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests += 5;
    if (rd_empty !== 1'b1) begin
      n_fail++; $display("FAIL rst_rd_empty: got %b expected 1", rd_empty);
    end
    if (almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL rst_almost_empty: got %b expected 1", almost_empty);
    end
    if (wr_full !== 1'b0) begin
      n_fail++; $display("FAIL rst_wr_full: got %b expected 0", wr_full);
    end
    if (almost_full !== 1'b0) begin
      n_fail++; $display("FAIL rst_almost_full: got %b expected 0", almost_full);
    end
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL rst_rd_data: got %0h expected 0", rd_data);
    end
    tb_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_fill();
    logic exp_af, exp_full;
    for (int i = 0; i <= Depth; i++) begin
      @(negedge clk);
      exp_af   = (i >= AF);
      exp_full = (i == Depth);
      n_tests += 2;
      if (almost_full !== exp_af) begin
        n_fail++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full, exp_af);
      end
      if (wr_full !== exp_full) begin
        n_fail++; $display("FAIL fill_wr_full[%0d]: got %b expected %b", i, wr_full, exp_full);
      end
      wr_en   = 1'b1;
      wr_data = (i < Depth) ? DW'(Depth - 1 - i) : DW'(10'h155);
    end
    @(negedge clk);
    n_tests++;
    if (wr_full !== 1'b1) begin
      n_fail++; $display("FAIL fill_drop_full: got %b expected 1", wr_full);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 0; i <= Depth; i++) begin
      @(negedge clk);
      n_tests++;
      if (rd_empty !== (i == Depth)) begin
        n_fail++; $display("FAIL drain_rd_empty[%0d]: got %b expected %b", i, rd_empty, i == Depth);
      end
      rd_en = 1'b1;
    end
    idle(4);
    n_tests += 2;
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL drain_hold: got %0h expected 0", rd_data);
    end
    if (rd_empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty: got %b expected 1", rd_empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = DW'(100 + i);
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n_tests += 2;
      if (almost_empty !== 1'b0) begin
        n_fail++; $display("FAIL sim_almost_empty[%0d]: got %b expected 0", i, almost_empty);
      end
      if (rd_empty !== 1'b0) begin
        n_fail++; $display("FAIL sim_rd_empty[%0d]: got %b expected 0", i, rd_empty);
      end
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = DW'(200 + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (4) @(negedge clk);
    idle(4);
    n_tests += 2;
    if (rd_empty !== 1'b1) begin
      n_fail++; $display("FAIL sim_final_empty: got %b expected 1", rd_empty);
    end
    if (rd_data !== DW'(200 + 1999)) begin
      n_fail++; $display("FAIL sim_final_data: got %0h expected %0h", rd_data, DW'(200 + 1999));
    end
  endtask

  task automatic test_boundaries();
    logic [DW-1:0] last_wd;
    last_wd = '0;
    for (int i = 0; i < Depth; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = DW'($urandom_range(0, Depth - 1));
      last_wd = wr_data;
    end
    @(negedge clk);
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = DW'(10'h0f0);
    @(negedge clk);
    n_tests += 3;
    if (wr_full !== 1'b0) begin
      n_fail++; $display("FAIL bnd_full_wr_full: got %b expected 0", wr_full);
    end
    if (almost_full !== 1'b1) begin
      n_fail++; $display("FAIL bnd_full_almost_full: got %b expected 1", almost_full);
    end
    if (rd_empty !== 1'b0) begin
      n_fail++; $display("FAIL bnd_full_rd_empty: got %b expected 0", rd_empty);
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (Depth - 2) @(negedge clk);
    idle(4);
    n_tests += 2;
    if (rd_empty !== 1'b1) begin
      n_fail++; $display("FAIL bnd_drain_empty: got %b expected 1", rd_empty);
    end
    if (rd_data !== last_wd) begin
      n_fail++; $display("FAIL bnd_drain_last: got %0h expected %0h", rd_data, last_wd);
    end
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = DW'(10'h2aa);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_tests += 3;
    if (rd_empty !== 1'b0) begin
      n_fail++; $display("FAIL bnd_empty_rd_empty: got %b expected 0", rd_empty);
    end
    if (almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL bnd_empty_almost_empty: got %b expected 1", almost_empty);
    end
    if (rd_data !== last_wd) begin
      n_fail++; $display("FAIL bnd_empty_hold: got %0h expected %0h", rd_data, last_wd);
    end
    idle(3);
    n_tests++;
    if (rd_data !== last_wd) begin
      n_fail++; $display("FAIL bnd_empty_hold_late: got %0h expected %0h", rd_data, last_wd);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    idle(3);
    n_tests += 2;
    if (rd_data !== DW'(10'h2aa)) begin
      n_fail++; $display("FAIL bnd_empty_write_data: got %0h expected 2aa", rd_data);
    end
    if (rd_empty !== 1'b1) begin
      n_fail++; $display("FAIL bnd_empty_final: got %b expected 1", rd_empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = DW'(i + 1);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    #1 tb_rst = 1'b1;
    #1;
    n_tests += 6;
    if (rd_empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_rd_empty: got %b expected 1", rd_empty);
    end
    if (almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_almost_empty: got %b expected 1", almost_empty);
    end
    if (wr_full !== 1'b0) begin
      n_fail++; $display("FAIL mid_wr_full: got %b expected 0", wr_full);
    end
    if (almost_full !== 1'b0) begin
      n_fail++; $display("FAIL mid_almost_full: got %b expected 0", almost_full);
    end
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL mid_rd_data: got %0h expected 0", rd_data);
    end
    if (dut.wr_ptr_q !== '0) begin
      n_fail++; $display("FAIL mid_wr_ptr: got %0h expected 0", dut.wr_ptr_q);
    end
    @(negedge clk);
    @(negedge clk);
    tb_rst  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL mid_inflight_discard: got %0h expected 0", rd_data);
    end
    wr_en   = 1'b1;
    wr_data = DW'(10'h3c3);
    @(negedge clk);
    wr_en = 1'b0;
    n_tests += 2;
    if (dut.wr_ptr_q !== 11'd1) begin
      n_fail++; $display("FAIL mid_wr_ptr_after: got %0h expected 1", dut.wr_ptr_q);
    end
    if (dut.mem[0] !== DW'(10'h3c3)) begin
      n_fail++; $display("FAIL mid_addr0: got %0h expected 3c3", dut.mem[0]);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    idle(3);
    n_tests++;
    if (rd_data !== DW'(10'h3c3)) begin
      n_fail++; $display("FAIL mid_readback: got %0h expected 3c3", rd_data);
    end
  endtask

  initial begin
    tb_rst  = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_boundaries();
    test_reset_mid();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
